// File: rtl/panel_io_hub_if.sv
// panel_io_hub_if: Avalon-MM slave bus plus level interrupt for the front-panel hub
interface panel_io_hub_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;
  modport slave (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata, irq);
  modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata, irq);
endinterface

// File: rtl/panel_io_hub.sv
// panel_io_hub: Avalon-MM front-panel peripheral for LEDs, switches, debounced keys with edge IRQ and hex digits
module panel_io_hub #(
  parameter int NUM_HEX         = 6,
  parameter int NUM_KEYS        = 4,
  parameter int NUM_LEDS        = 10,
  parameter int NUM_SW          = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  panel_io_hub_if.slave         avs,
  output logic [7*NUM_HEX-1:0]  hex_export,
  input  logic [NUM_KEYS-1:0]   keys_export,
  output logic [NUM_LEDS-1:0]   leds_export,
  input  logic [NUM_SW-1:0]     sw_export
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic [NUM_SW-1:0]     sw1_q, sw1_d, sw2_q, sw2_d;
  logic [NUM_KEYS-1:0]   k1_q, k1_d, k2_q, k2_d, stable_q, stable_d;
  logic [NUM_KEYS-1:0]   edge_q, edge_d, mask_q, mask_d;
  logic [CW-1:0]         cnt_q [NUM_KEYS];
  logic [CW-1:0]         cnt_d [NUM_KEYS];
  logic [4*NUM_HEX-1:0]  hexval_q, hexval_d;
  logic [NUM_HEX-1:0]    blank_q, blank_d;
  logic [7*NUM_HEX-1:0]  hex_q, hex_d;
  logic                  irq_q, irq_d;
  logic [31:0]           rdata_q, rdata_d, rd;
  logic                  unused_wd;
  logic [7:0]            wsel;
  assign unused_wd = ^avs.avs_writedata;
  always_comb begin
    wsel = avs.avs_write ? 8'(1) << avs.avs_address : 8'h00;
    led_d = wsel[0] ? avs.avs_writedata[NUM_LEDS-1:0] : led_q;
    mask_d = wsel[4] ? avs.avs_writedata[NUM_KEYS-1:0] : mask_q;
    hexval_d = wsel[5] ? avs.avs_writedata[4*NUM_HEX-1:0] : hexval_q;
    blank_d = wsel[6] ? avs.avs_writedata[NUM_HEX-1:0] : blank_q;
    sw1_d = sw_export;
    sw2_d = sw1_q;
    k1_d = KEY_ACTIVE_LOW != 0 ? ~keys_export : keys_export;
    k2_d = k1_q;
    stable_d = stable_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k2_q[i] == stable_q[i]) cnt_d[i] = '0;
      else if (cnt_q[i] == LAST) begin
        stable_d[i] = k2_q[i];
        cnt_d[i] = '0;
      end else cnt_d[i] = cnt_q[i] + CW'(1);
    end
    // a press landing on the same edge as its W1C must survive, so the set term is ORed last
    edge_d = (edge_q & ~(wsel[3] ? avs.avs_writedata[NUM_KEYS-1:0] : '0)) | (stable_d & ~stable_q);
    irq_d = |(edge_q & mask_q);
    hex_d = '1;
    for (int h = 0; h < NUM_HEX; h++)
      hex_d[7*h +: 7] = blank_q[h] ? 7'h7F : SEG[hexval_q[4*h +: 4]];
    case (avs.avs_address)
      3'd0: rd = 32'(led_q);
      3'd1: rd = 32'(sw2_q);
      3'd2: rd = 32'(stable_q);
      3'd3: rd = 32'(edge_q);
      3'd4: rd = 32'(mask_q);
      3'd5: rd = 32'(hexval_q);
      3'd6: rd = 32'(blank_q);
      default: rd = '0;
    endcase
    rdata_d = avs.avs_read ? rd : rdata_q;
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      led_q <= '0;
      sw1_q <= '0;
      sw2_q <= '0;
      k1_q <= '0;
      k2_q <= '0;
      stable_q <= '0;
      cnt_q <= '{default: '0};
      edge_q <= '0;
      mask_q <= '0;
      hexval_q <= '0;
      blank_q <= '1;
      hex_q <= '1;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      led_q <= led_d;
      sw1_q <= sw1_d;
      sw2_q <= sw2_d;
      k1_q <= k1_d;
      k2_q <= k2_d;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
      edge_q <= edge_d;
      mask_q <= mask_d;
      hexval_q <= hexval_d;
      blank_q <= blank_d;
      hex_q <= hex_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  assign avs.avs_readdata = rdata_q;
  assign avs.irq = irq_q;
  assign leds_export = led_q;
  assign hex_export = hex_q;
endmodule

// File: tb/tb_panel_io_hub.sv
// tb_panel_io_hub: directed self-checking bench for panel_io_hub with a short debounce window
module tb_panel_io_hub;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] keys;
  logic [9:0] sw;
  logic [41:0] hex;
  logic [9:0] leds;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  panel_io_hub_if bus();
  panel_io_hub #(.DEBOUNCE_CYCLES(16)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .avs(bus.slave), .hex_export(hex),
    .keys_export(keys), .leds_export(leds), .sw_export(sw));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    chk(tag, 64'(bus.avs_readdata), 64'(exp));
  endtask
  initial begin
    rst_n = 1'b0;
    keys = 4'hF;
    sw = 10'h2A5;
    bus.avs_address = '0;
    bus.avs_read = 1'b0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_hex", 64'(hex), 64'({42{1'b1}}));
    chk("reset_leds", 64'(leds), 64'h0);
    chk("reset_irq", 64'(bus.irq), 64'h0);
    chk("reset_readdata", 64'(bus.avs_readdata), 64'h0);
    rd_chk("reset_led_reg", 3'd0, 32'h0);
    rd_chk("reset_key_reg", 3'd2, 32'h0);
    rd_chk("reset_edge_reg", 3'd3, 32'h0);
    rd_chk("reset_mask_reg", 3'd4, 32'h0);
    rd_chk("reset_hexval_reg", 3'd5, 32'h0);
    rd_chk("reset_blank_reg", 3'd6, 32'h3F);
    rd_chk("rsvd_reg", 3'd7, 32'h0);
    rd_chk("sw_reg", 3'd1, 32'h2A5);
    wr(3'd0, 32'hFFFF_FFFF);
    chk("led_pins", 64'(leds), 64'h3FF);
    rd_chk("led_reg", 3'd0, 32'h3FF);
    wr(3'd0, 32'h0000_0155);
    chk("led_pins_2", 64'(leds), 64'h155);
    chk("readdata_held", 64'(bus.avs_readdata), 64'h3FF);
    @(negedge clk);
    keys = 4'hE;
    repeat (10) @(negedge clk);
    keys = 4'hF;
    repeat (20) @(negedge clk);
    rd_chk("glitch_key", 3'd2, 32'h0);
    rd_chk("glitch_edge", 3'd3, 32'h0);
    keys = 4'hE;
    repeat (20) @(negedge clk);
    rd_chk("press_key", 3'd2, 32'h1);
    rd_chk("press_edge", 3'd3, 32'h1);
    keys = 4'hF;
    repeat (25) @(negedge clk);
    rd_chk("release_key", 3'd2, 32'h0);
    rd_chk("release_edge_kept", 3'd3, 32'h1);
    chk("irq_masked", 64'(bus.irq), 64'h0);
    wr(3'd4, 32'h1);
    chk("irq_latency", 64'(bus.irq), 64'h0);
    @(negedge clk);
    chk("irq_set", 64'(bus.irq), 64'h1);
    wr(3'd3, 32'h1);
    rd_chk("edge_w1c", 3'd3, 32'h0);
    chk("irq_cleared", 64'(bus.irq), 64'h0);
    keys = 4'hE;
    repeat (17) @(negedge clk);
    bus.avs_address = 3'd3;
    bus.avs_writedata = 32'h1;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
    rd_chk("set_beats_w1c", 3'd3, 32'h1);
    rd_chk("press2_key", 3'd2, 32'h1);
    chk("irq_press2", 64'(bus.irq), 64'h1);
    keys = 4'hF;
    repeat (25) @(negedge clk);
    wr(3'd5, 32'h00F810);
    wr(3'd6, 32'h3E);
    chk("hex_latency", 64'(hex), 64'({42{1'b1}}));
    @(negedge clk);
    chk("hex_blank_3e", 64'(hex), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}));
    wr(3'd6, 32'h30);
    @(negedge clk);
    chk("hex_blank_30", 64'(hex), 64'({7'h7F, 7'h7F, 7'h0E, 7'h00, 7'h79, 7'h40}));
    wr(3'd5, 32'h765432);
    wr(3'd6, 32'h0);
    @(negedge clk);
    chk("hex_765432", 64'(hex), 64'({7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24}));
    rd_chk("hexval_reg", 3'd5, 32'h765432);
    wr(3'd3, 32'hF);
    keys = 4'hE;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_leds", 64'(leds), 64'h0);
    chk("async_reset_hex", 64'(hex), 64'({42{1'b1}}));
    keys = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    rd_chk("midrst_key", 3'd2, 32'h0);
    rd_chk("midrst_edge", 3'd3, 32'h0);
    rd_chk("midrst_mask", 3'd4, 32'h0);
    chk("midrst_irq", 64'(bus.irq), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
